// File: rtl/cva6_axi_mem_responder.sv
// AXI4 subordinate backed by a word-addressed register array.
// Independent write (AW/W/B) and read (AR/R) engines, one burst each in flight.
module cva6_axi_mem_responder #(
  parameter int unsigned AXI_ADDRESS_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH    = 64,
  parameter int unsigned AXI_ID_WIDTH      = 4,
  parameter logic [63:0] MEM_BASE          = 64'h8000_0000,
  parameter int unsigned MEM_WORDS         = 4096
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            axi_req_i_aw_valid,
  output logic                            axi_resp_o_aw_ready,
  input  logic [AXI_ID_WIDTH-1:0]         axi_req_i_aw_bits_id,
  input  logic [AXI_ADDRESS_WIDTH-1:0]    axi_req_i_aw_bits_addr,
  input  logic [7:0]                      axi_req_i_aw_bits_len,
  input  logic [2:0]                      axi_req_i_aw_bits_size,
  input  logic [1:0]                      axi_req_i_aw_bits_burst,
  input  logic                            axi_req_i_ar_valid,
  output logic                            axi_resp_o_ar_ready,
  input  logic [AXI_ID_WIDTH-1:0]         axi_req_i_ar_bits_id,
  input  logic [AXI_ADDRESS_WIDTH-1:0]    axi_req_i_ar_bits_addr,
  input  logic [7:0]                      axi_req_i_ar_bits_len,
  input  logic [2:0]                      axi_req_i_ar_bits_size,
  input  logic [1:0]                      axi_req_i_ar_bits_burst,
  input  logic                            axi_req_i_w_valid,
  output logic                            axi_resp_o_w_ready,
  input  logic [AXI_DATA_WIDTH-1:0]       axi_req_i_w_bits_data,
  input  logic [AXI_DATA_WIDTH/8-1:0]     axi_req_i_w_bits_strb,
  input  logic                            axi_req_i_w_bits_last,
  output logic                            axi_resp_o_b_valid,
  input  logic                            axi_req_i_b_ready,
  output logic [AXI_ID_WIDTH-1:0]         axi_resp_o_b_bits_id,
  output logic [1:0]                      axi_resp_o_b_bits_resp,
  output logic                            axi_resp_o_r_valid,
  input  logic                            axi_req_i_r_ready,
  output logic [AXI_ID_WIDTH-1:0]         axi_resp_o_r_bits_id,
  output logic [AXI_DATA_WIDTH-1:0]       axi_resp_o_r_bits_data,
  output logic [1:0]                      axi_resp_o_r_bits_resp,
  output logic                            axi_resp_o_r_bits_last
);

  localparam int unsigned AW     = AXI_ADDRESS_WIDTH;
  localparam int unsigned DW     = AXI_DATA_WIDTH;
  localparam int unsigned IW     = AXI_ID_WIDTH;
  localparam int unsigned STRB_W = DW / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
  localparam logic [AW-1:0] BASE = AW'(MEM_BASE);
  localparam logic [1:0] RESP_OKAY = 2'd0, RESP_SLVERR = 2'd2, RESP_DECERR = 2'd3;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA} r_state_e;

  logic [DW-1:0] mem [0:MEM_WORDS-1];

  // Address of the beat following a, for the latched burst attributes.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic [7:0] len,
                                              input logic [2:0] size, input logic [1:0] burst);
    logic [AW-1:0] step, incr, wmask;
    step      = AW'(1) << size;
    incr      = (a & ~(step - AW'(1))) + step;
    wmask     = ((AW'(len) + AW'(1)) << size) - AW'(1);
    next_addr = incr;
    if (burst == 2'd0) next_addr = a;
    else if (burst == 2'd2 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
      next_addr = (a & ~wmask) | ((a + step) & wmask);
  endfunction

  function automatic logic in_range(input logic [AW-1:0] a);
    logic [AW-1:0] off;
    off      = a - BASE;
    in_range = (a >= BASE) && ((off >> OFF_W) < AW'(MEM_WORDS));
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [AW-1:0] a);
    word_idx = IDX_W'((a - BASE) >> OFF_W);
  endfunction

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  logic [AW-1:0] w_addr_q, w_addr_d, r_addr_q, r_addr_d;
  logic [7:0]    w_len_q, w_len_d, r_len_q, r_len_d, w_cnt_q, w_cnt_d, r_cnt_q, r_cnt_d;
  logic [2:0]    w_size_q, w_size_d, r_size_q, r_size_d;
  logic [1:0]    w_burst_q, w_burst_d, r_burst_q, r_burst_d;
  logic          w_decerr_q, w_decerr_d, w_slverr_q, w_slverr_d;
  logic          aw_ready_q, aw_ready_d, w_ready_q, w_ready_d, b_valid_q, b_valid_d;
  logic [IW-1:0] b_id_q, b_id_d, r_id_q, r_id_d;
  logic [1:0]    b_resp_q, b_resp_d, r_resp_q, r_resp_d;
  logic          ar_ready_q, ar_ready_d, r_valid_q, r_valid_d, r_last_q, r_last_d;
  logic [DW-1:0] r_data_q, r_data_d;
  logic          mem_we_c;
  logic [AW-1:0] rd_addr_c;
  logic          rd_hit_c;
  logic [DW-1:0] rd_data_c;

  // Write engine: accept AW, absorb W beats into memory, then report B.
  always_comb begin
    w_state_d  = w_state_q;  w_addr_d   = w_addr_q;   w_len_d   = w_len_q;
    w_size_d   = w_size_q;   w_burst_d  = w_burst_q;  w_cnt_d   = w_cnt_q;
    w_decerr_d = w_decerr_q; w_slverr_d = w_slverr_q;
    aw_ready_d = aw_ready_q; w_ready_d  = w_ready_q;  b_valid_d = b_valid_q;
    b_id_d     = b_id_q;     b_resp_d   = b_resp_q;
    mem_we_c   = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        aw_ready_d = 1'b1;
        if (axi_req_i_aw_valid && aw_ready_q) begin
          b_id_d     = axi_req_i_aw_bits_id;
          w_addr_d   = axi_req_i_aw_bits_addr;
          w_len_d    = axi_req_i_aw_bits_len;
          w_size_d   = axi_req_i_aw_bits_size;
          w_burst_d  = axi_req_i_aw_bits_burst;
          w_cnt_d    = 8'd0;
          w_decerr_d = 1'b0;
          w_slverr_d = 1'b0;
          aw_ready_d = 1'b0;
          w_ready_d  = 1'b1;
          w_state_d  = W_DATA;
        end
      end
      W_DATA: begin
        if (axi_req_i_w_valid && w_ready_q) begin
          if (in_range(w_addr_q)) mem_we_c = 1'b1;
          else                    w_decerr_d = 1'b1;
          if (axi_req_i_w_bits_last != (w_cnt_q == w_len_q)) w_slverr_d = 1'b1;
          w_addr_d = next_addr(w_addr_q, w_len_q, w_size_q, w_burst_q);
          w_cnt_d  = w_cnt_q + 8'd1;
          if (w_cnt_q == w_len_q) begin
            w_ready_d = 1'b0;
            b_valid_d = 1'b1;
            b_resp_d  = w_decerr_d ? RESP_DECERR : (w_slverr_d ? RESP_SLVERR : RESP_OKAY);
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (b_valid_q && axi_req_i_b_ready) begin
          b_valid_d  = 1'b0;
          aw_ready_d = 1'b1;
          w_state_d  = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read lookup: beat 0 comes from the AR bus, later beats from the advanced address.
  always_comb begin
    rd_addr_c = (r_state_q == R_IDLE) ? axi_req_i_ar_bits_addr
                                      : next_addr(r_addr_q, r_len_q, r_size_q, r_burst_q);
    rd_hit_c  = in_range(rd_addr_c);
    rd_data_c = rd_hit_c ? mem[word_idx(rd_addr_c)] : '0;
  end

  // Read engine: accept AR, present one registered beat at a time on R.
  always_comb begin
    r_state_d  = r_state_q;  r_addr_d  = r_addr_q;  r_len_d  = r_len_q;
    r_size_d   = r_size_q;   r_burst_d = r_burst_q; r_cnt_d  = r_cnt_q;
    ar_ready_d = ar_ready_q; r_valid_d = r_valid_q; r_id_d   = r_id_q;
    r_data_d   = r_data_q;   r_resp_d  = r_resp_q;  r_last_d = r_last_q;
    case (r_state_q)
      R_IDLE: begin
        ar_ready_d = 1'b1;
        if (axi_req_i_ar_valid && ar_ready_q) begin
          r_id_d     = axi_req_i_ar_bits_id;
          r_addr_d   = axi_req_i_ar_bits_addr;
          r_len_d    = axi_req_i_ar_bits_len;
          r_size_d   = axi_req_i_ar_bits_size;
          r_burst_d  = axi_req_i_ar_bits_burst;
          r_cnt_d    = 8'd0;
          r_data_d   = rd_data_c;
          r_resp_d   = rd_hit_c ? RESP_OKAY : RESP_DECERR;
          r_last_d   = (axi_req_i_ar_bits_len == 8'd0);
          r_valid_d  = 1'b1;
          ar_ready_d = 1'b0;
          r_state_d  = R_DATA;
        end
      end
      R_DATA: begin
        if (r_valid_q && axi_req_i_r_ready) begin
          if (r_last_q) begin
            r_valid_d  = 1'b0;
            r_last_d   = 1'b0;
            ar_ready_d = 1'b1;
            r_state_d  = R_IDLE;
          end else begin
            r_addr_d = rd_addr_c;
            r_cnt_d  = r_cnt_q + 8'd1;
            r_data_d = rd_data_c;
            r_resp_d = rd_hit_c ? RESP_OKAY : RESP_DECERR;
            r_last_d = ((r_cnt_q + 8'd1) == r_len_q);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // State and output registers for both engines.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_state_q <= W_IDLE; w_addr_q <= '0; w_len_q <= '0; w_size_q <= '0; w_burst_q <= '0;
      w_cnt_q <= '0; w_decerr_q <= 1'b0; w_slverr_q <= 1'b0;
      aw_ready_q <= 1'b0; w_ready_q <= 1'b0; b_valid_q <= 1'b0; b_id_q <= '0; b_resp_q <= '0;
      r_state_q <= R_IDLE; r_addr_q <= '0; r_len_q <= '0; r_size_q <= '0; r_burst_q <= '0;
      r_cnt_q <= '0; ar_ready_q <= 1'b0; r_valid_q <= 1'b0; r_id_q <= '0; r_data_q <= '0;
      r_resp_q <= '0; r_last_q <= 1'b0;
    end else begin
      w_state_q <= w_state_d; w_addr_q <= w_addr_d; w_len_q <= w_len_d; w_size_q <= w_size_d;
      w_burst_q <= w_burst_d; w_cnt_q <= w_cnt_d; w_decerr_q <= w_decerr_d; w_slverr_q <= w_slverr_d;
      aw_ready_q <= aw_ready_d; w_ready_q <= w_ready_d; b_valid_q <= b_valid_d;
      b_id_q <= b_id_d; b_resp_q <= b_resp_d;
      r_state_q <= r_state_d; r_addr_q <= r_addr_d; r_len_q <= r_len_d; r_size_q <= r_size_d;
      r_burst_q <= r_burst_d; r_cnt_q <= r_cnt_d; ar_ready_q <= ar_ready_d; r_valid_q <= r_valid_d;
      r_id_q <= r_id_d; r_data_q <= r_data_d; r_resp_q <= r_resp_d; r_last_q <= r_last_d;
    end
  end

  // Byte-strobed memory write; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (mem_we_c) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (axi_req_i_w_bits_strb[b])
          mem[word_idx(w_addr_q)][8*b +: 8] <= axi_req_i_w_bits_data[8*b +: 8];
      end
    end
  end

  assign axi_resp_o_aw_ready    = aw_ready_q;
  assign axi_resp_o_ar_ready    = ar_ready_q;
  assign axi_resp_o_w_ready     = w_ready_q;
  assign axi_resp_o_b_valid     = b_valid_q;
  assign axi_resp_o_b_bits_id   = b_id_q;
  assign axi_resp_o_b_bits_resp = b_resp_q;
  assign axi_resp_o_r_valid     = r_valid_q;
  assign axi_resp_o_r_bits_id   = r_id_q;
  assign axi_resp_o_r_bits_data = r_data_q;
  assign axi_resp_o_r_bits_resp = r_resp_q;
  assign axi_resp_o_r_bits_last = r_last_q;

endmodule

// File: tb/tb_cva6_axi_mem_responder.sv
// Directed testbench for cva6_axi_mem_responder (default parameters).
module tb_cva6_axi_mem_responder;

  localparam logic [63:0] BASE = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        aw_valid = 0, ar_valid = 0, w_valid = 0, w_last = 0, b_ready = 1, r_ready = 1;
  logic [3:0]  aw_id = 0, ar_id = 0;
  logic [63:0] aw_addr = 0, ar_addr = 0, w_data = 0;
  logic [7:0]  aw_len = 0, ar_len = 0, w_strb = 0;
  logic [2:0]  aw_size = 3'd3, ar_size = 3'd3;
  logic [1:0]  aw_burst = 1, ar_burst = 1;
  logic        aw_ready, ar_ready, w_ready, b_valid, r_valid, r_last;
  logic [3:0]  b_id, r_id;
  logic [1:0]  b_resp, r_resp;
  logic [63:0] r_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cva6_axi_mem_responder dut (
    .clk_i(clk), .rst_i(rst),
    .axi_req_i_aw_valid(aw_valid), .axi_resp_o_aw_ready(aw_ready),
    .axi_req_i_aw_bits_id(aw_id), .axi_req_i_aw_bits_addr(aw_addr),
    .axi_req_i_aw_bits_len(aw_len), .axi_req_i_aw_bits_size(aw_size),
    .axi_req_i_aw_bits_burst(aw_burst),
    .axi_req_i_ar_valid(ar_valid), .axi_resp_o_ar_ready(ar_ready),
    .axi_req_i_ar_bits_id(ar_id), .axi_req_i_ar_bits_addr(ar_addr),
    .axi_req_i_ar_bits_len(ar_len), .axi_req_i_ar_bits_size(ar_size),
    .axi_req_i_ar_bits_burst(ar_burst),
    .axi_req_i_w_valid(w_valid), .axi_resp_o_w_ready(w_ready),
    .axi_req_i_w_bits_data(w_data), .axi_req_i_w_bits_strb(w_strb),
    .axi_req_i_w_bits_last(w_last),
    .axi_resp_o_b_valid(b_valid), .axi_req_i_b_ready(b_ready),
    .axi_resp_o_b_bits_id(b_id), .axi_resp_o_b_bits_resp(b_resp),
    .axi_resp_o_r_valid(r_valid), .axi_req_i_r_ready(r_ready),
    .axi_resp_o_r_bits_id(r_id), .axi_resp_o_r_bits_data(r_data),
    .axi_resp_o_r_bits_resp(r_resp), .axi_resp_o_r_bits_last(r_last)
  );

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_aw(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                       input logic [1:0] burst);
    aw_id = id; aw_addr = addr; aw_len = len; aw_size = 3'd3; aw_burst = burst; aw_valid = 1'b1;
    for (int i = 0; i < 50 && !aw_ready; i++) step();
    if (!aw_ready) begin
      checks++; errors++; $display("FAIL aw_timeout: aw_ready=%b required 1", aw_ready);
    end
    step();
    aw_valid = 1'b0;
  endtask

  task automatic do_ar(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                       input logic [1:0] burst);
    ar_id = id; ar_addr = addr; ar_len = len; ar_size = 3'd3; ar_burst = burst; ar_valid = 1'b1;
    for (int i = 0; i < 50 && !ar_ready; i++) step();
    if (!ar_ready) begin
      checks++; errors++; $display("FAIL ar_timeout: ar_ready=%b required 1", ar_ready);
    end
    step();
    ar_valid = 1'b0;
  endtask

  task automatic w_beat(input logic [63:0] data, input logic [7:0] strb, input logic last);
    w_data = data; w_strb = strb; w_last = last; w_valid = 1'b1;
    for (int i = 0; i < 50 && !w_ready; i++) step();
    if (!w_ready) begin
      checks++; errors++; $display("FAIL w_timeout: w_ready=%b required 1", w_ready);
    end
    step();
    w_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({aw_ready, ar_ready, w_ready, b_valid, r_valid, r_last, b_resp, r_resp, b_id, r_id, r_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: aw_rdy=%b ar_rdy=%b w_rdy=%b bv=%b rv=%b rl=%b bresp=%0d rresp=%0d bid=%0d rid=%0d rdata=%h required all 0",
               aw_ready, ar_ready, w_ready, b_valid, r_valid, r_last, b_resp, r_resp, b_id, r_id, r_data);
    end
    rst = 1'b0;
    checks++;
    if ({aw_ready, ar_ready} !== 2'b00) begin
      errors++; $display("FAIL release_ready_early: aw/ar_ready=%b required 00", {aw_ready, ar_ready});
    end
    step();
    checks++;
    if ({aw_ready, ar_ready, w_ready} !== 3'b110) begin
      errors++; $display("FAIL ready_after_release: aw/ar/w_ready=%b required 110", {aw_ready, ar_ready, w_ready});
    end
  endtask

  task automatic test_single_beat();
    do_aw(4'd3, BASE, 8'd0, 2'd1);
    w_beat(64'hDEADBEEF_CAFEF00D, 8'hFF, 1'b1);
    checks++;
    if ({b_valid, b_id, b_resp, aw_ready} !== {1'b1, 4'd3, 2'd0, 1'b0}) begin
      errors++; $display("FAIL single_b: valid/id/resp/aw_rdy=%b/%0d/%0d/%b required 1/3/0/0", b_valid, b_id, b_resp, aw_ready);
    end
    step();
    checks++;
    if ({b_valid, aw_ready} !== 2'b01) begin
      errors++; $display("FAIL single_b_done: b_valid/aw_ready=%b required 01", {b_valid, aw_ready});
    end
    do_ar(4'd5, BASE, 8'd0, 2'd1);
    checks++;
    if ({r_valid, r_id, r_data, r_resp, r_last, ar_ready} !== {1'b1, 4'd5, 64'hDEADBEEF_CAFEF00D, 2'd0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL single_r: valid=%b id=%0d data=%h resp=%0d last=%b ar_rdy=%b required 1 5 deadbeefcafef00d 0 1 0",
                         r_valid, r_id, r_data, r_resp, r_last, ar_ready);
    end
    step();
    checks++;
    if ({r_valid, ar_ready} !== 2'b01) begin
      errors++; $display("FAIL single_r_done: r_valid/ar_ready=%b required 01", {r_valid, ar_ready});
    end
  endtask

  task automatic test_incr();
    do_aw(4'd1, BASE + 64'h20, 8'd3, 2'd1);
    for (int i = 0; i < 4; i++) w_beat(64'(i + 1), 8'hFF, i == 3);
    checks++;
    if ({b_valid, b_id, b_resp} !== {1'b1, 4'd1, 2'd0}) begin
      errors++; $display("FAIL incr_b: valid/id/resp=%b/%0d/%0d required 1/1/0", b_valid, b_id, b_resp);
    end
    step();
    do_ar(4'd2, BASE + 64'h20, 8'd3, 2'd1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({r_valid, r_id, r_data, r_resp, r_last} !== {1'b1, 4'd2, 64'(i + 1), 2'd0, i == 3}) begin
        errors++; $display("FAIL incr_r beat %0d: valid=%b id=%0d data=%h resp=%0d last=%b required 1 2 %h 0 %b",
                           i, r_valid, r_id, r_data, r_resp, r_last, 64'(i + 1), i == 3);
      end
      step();
    end
    checks++;
    if (r_valid !== 1'b0) begin
      errors++; $display("FAIL incr_r_end: r_valid=%b required 0", r_valid);
    end
    do_aw(4'd1, BASE + 64'h40, 8'd0, 2'd1);
    w_beat(64'd0, 8'hFF, 1'b1);
    step();
    do_aw(4'd1, BASE + 64'h40, 8'd0, 2'd1);
    w_beat(64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1'b1);
    step();
    do_ar(4'd2, BASE + 64'h40, 8'd0, 2'd1);
    checks++;
    if ({r_data, r_resp} !== {64'h0000_0000_FFFF_FFFF, 2'd0}) begin
      errors++; $display("FAIL narrow_write: data=%h resp=%0d required 00000000ffffffff 0", r_data, r_resp);
    end
    step();
  endtask

  task automatic test_wrap();
    logic [63:0] exp [4];
    exp = '{64'd13, 64'd10, 64'd11, 64'd12};
    do_aw(4'd2, BASE, 8'd3, 2'd1);
    for (int i = 0; i < 4; i++) w_beat(64'(10 + i), 8'hFF, i == 3);
    step();
    do_ar(4'd6, BASE + 64'h18, 8'd3, 2'd2);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({r_valid, r_id, r_data, r_resp, r_last} !== {1'b1, 4'd6, exp[i], 2'd0, i == 3}) begin
        errors++; $display("FAIL wrap_r beat %0d: valid=%b id=%0d data=%h resp=%0d last=%b required 1 6 %h 0 %b",
                           i, r_valid, r_id, r_data, r_resp, r_last, exp[i], i == 3);
      end
      step();
    end
  endtask

  task automatic test_errors();
    do_ar(4'd7, BASE - 64'd8, 8'd1, 2'd0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({r_valid, r_id, r_data, r_resp, r_last} !== {1'b1, 4'd7, 64'd0, 2'd3, i == 1}) begin
        errors++; $display("FAIL decerr_fixed beat %0d: valid=%b id=%0d data=%h resp=%0d last=%b required 1 7 0 3 %b",
                           i, r_valid, r_id, r_data, r_resp, r_last, i == 1);
      end
      step();
    end
    // INCR crossing from below the base into word 0: only the first beat errors.
    do_ar(4'd7, BASE - 64'd8, 8'd1, 2'd1);
    checks++;
    if ({r_data, r_resp, r_last} !== {64'd0, 2'd3, 1'b0}) begin
      errors++; $display("FAIL decerr_cross0: data=%h resp=%0d last=%b required 0 3 0", r_data, r_resp, r_last);
    end
    step();
    checks++;
    if ({r_valid, r_data, r_resp, r_last} !== {1'b1, 64'd10, 2'd0, 1'b1}) begin
      errors++; $display("FAIL decerr_cross1: valid=%b data=%h resp=%0d last=%b required 1 a 0 1", r_valid, r_data, r_resp, r_last);
    end
    step();
    do_aw(4'd8, BASE + 64'h8000, 8'd0, 2'd1);
    w_beat(64'h55, 8'hFF, 1'b1);
    checks++;
    if ({b_valid, b_id, b_resp} !== {1'b1, 4'd8, 2'd3}) begin
      errors++; $display("FAIL decerr_write: valid/id/resp=%b/%0d/%0d required 1/8/3", b_valid, b_id, b_resp);
    end
    step();
    do_ar(4'd8, BASE, 8'd0, 2'd1);
    checks++;
    if (r_data !== 64'd10) begin
      errors++; $display("FAIL decerr_no_alias: word0=%h required a", r_data);
    end
    step();
    do_aw(4'd9, BASE + 64'h100, 8'd3, 2'd1);
    for (int i = 0; i < 4; i++) begin
      w_beat(64'(i), 8'hFF, i == 1);
      if (i == 1) begin
        checks++;
        if ({w_ready, b_valid} !== 2'b10) begin
          errors++; $display("FAIL early_last_continue: w_ready/b_valid=%b required 10", {w_ready, b_valid});
        end
      end
    end
    checks++;
    if ({b_valid, b_id, b_resp} !== {1'b1, 4'd9, 2'd2}) begin
      errors++; $display("FAIL early_last_b: valid/id/resp=%b/%0d/%0d required 1/9/2", b_valid, b_id, b_resp);
    end
    step();
  endtask

  task automatic test_backpressure();
    do_aw(4'd7, BASE + 64'h200, 8'd3, 2'd1);
    b_ready = 1'b0;
    for (int i = 0; i < 4; i++) w_beat(64'hA0 + 64'(i), 8'hFF, i == 3);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if ({b_valid, b_id, b_resp} !== {1'b1, 4'd7, 2'd0}) begin
        errors++; $display("FAIL b_hold cycle %0d: valid/id/resp=%b/%0d/%0d required 1/7/0", c, b_valid, b_id, b_resp);
      end
      if (c < 3) step();
    end
    b_ready = 1'b1;
    step();
    checks++;
    if (b_valid !== 1'b0) begin
      errors++; $display("FAIL b_release: b_valid=%b required 0", b_valid);
    end
    do_ar(4'd3, BASE + 64'h200, 8'd3, 2'd1);
    checks++;
    if ({r_valid, r_id, r_data, r_last} !== {1'b1, 4'd3, 64'hA0, 1'b0}) begin
      errors++; $display("FAIL bp_r beat 0: valid=%b id=%0d data=%h last=%b required 1 3 a0 0", r_valid, r_id, r_data, r_last);
    end
    step();
    r_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({r_valid, r_id, r_data, r_resp, r_last} !== {1'b1, 4'd3, 64'hA1, 2'd0, 1'b0}) begin
        errors++; $display("FAIL r_hold cycle %0d: valid=%b id=%0d data=%h resp=%0d last=%b required 1 3 a1 0 0",
                           c, r_valid, r_id, r_data, r_resp, r_last);
      end
      step();
    end
    r_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      checks++;
      if ({r_valid, r_data, r_last} !== {1'b1, 64'hA0 + 64'(i), i == 3}) begin
        errors++; $display("FAIL bp_r beat %0d: valid=%b data=%h last=%b required 1 %h %b",
                           i, r_valid, r_data, r_last, 64'hA0 + 64'(i), i == 3);
      end
      step();
    end
  endtask

  task automatic test_concurrent();
    checks++;
    if ({aw_ready, ar_ready} !== 2'b11) begin
      errors++; $display("FAIL conc_ready: aw/ar_ready=%b required 11", {aw_ready, ar_ready});
    end
    aw_id = 4'd9; aw_addr = BASE + 64'h300; aw_len = 8'd1; aw_burst = 2'd1; aw_valid = 1'b1;
    ar_id = 4'hA; ar_addr = BASE + 64'h200; ar_len = 8'd1; ar_burst = 2'd1; ar_valid = 1'b1;
    step();
    aw_valid = 1'b0; ar_valid = 1'b0;
    w_data = 64'h77; w_strb = 8'hFF; w_last = 1'b0; w_valid = 1'b1;
    checks++;
    if ({r_valid, r_id, r_data, r_last, w_ready} !== {1'b1, 4'hA, 64'hA0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL conc_beat0: rv=%b id=%0d data=%h last=%b w_rdy=%b required 1 10 a0 0 1", r_valid, r_id, r_data, r_last, w_ready);
    end
    step();
    w_data = 64'h88; w_last = 1'b1;
    checks++;
    if ({r_valid, r_id, r_data, r_last, w_ready} !== {1'b1, 4'hA, 64'hA1, 1'b1, 1'b1}) begin
      errors++; $display("FAIL conc_beat1: rv=%b id=%0d data=%h last=%b w_rdy=%b required 1 10 a1 1 1", r_valid, r_id, r_data, r_last, w_ready);
    end
    step();
    w_valid = 1'b0;
    checks++;
    if ({b_valid, b_id, b_resp, r_valid} !== {1'b1, 4'd9, 2'd0, 1'b0}) begin
      errors++; $display("FAIL conc_end: bv=%b bid=%0d bresp=%0d rv=%b required 1 9 0 0", b_valid, b_id, b_resp, r_valid);
    end
    step();
    do_ar(4'hB, BASE + 64'h300, 8'd1, 2'd1);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({r_id, r_data, r_last} !== {4'hB, (i == 0) ? 64'h77 : 64'h88, i == 1}) begin
        errors++; $display("FAIL conc_readback beat %0d: id=%0d data=%h last=%b", i, r_id, r_data, r_last);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_burst();
    do_aw(4'd4, BASE + 64'h400, 8'd3, 2'd1);
    w_beat(64'h11, 8'hFF, 1'b0);
    w_beat(64'h22, 8'hFF, 1'b0);
    rst = 1'b1;
    #1;
    checks++;
    if ({aw_ready, ar_ready, w_ready, b_valid, r_valid} !== 5'b0) begin
      errors++; $display("FAIL midburst_reset: aw/ar/w_rdy bv rv=%b required 00000", {aw_ready, ar_ready, w_ready, b_valid, r_valid});
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if (aw_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_aw_ready: aw_ready=%b required 1", aw_ready);
    end
    do_aw(4'd4, BASE + 64'h500, 8'd0, 2'd1);
    checks++;
    if ({aw_ready, w_ready} !== 2'b01) begin
      errors++; $display("FAIL post_reset_aw_accept: aw/w_ready=%b required 01", {aw_ready, w_ready});
    end
    w_beat(64'h33, 8'hFF, 1'b1);
    step();
    do_ar(4'd1, BASE + 64'h400, 8'd1, 2'd1);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({r_valid, r_data, r_resp, r_last} !== {1'b1, (i == 0) ? 64'h11 : 64'h22, 2'd0, i == 1}) begin
        errors++; $display("FAIL persist beat %0d: valid=%b data=%h resp=%0d last=%b", i, r_valid, r_data, r_resp, r_last);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_incr();
    test_wrap();
    test_errors();
    test_backpressure();
    test_concurrent();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
